// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stage-enable / flush sequencing for the 5-stage pipeline.
// Resolves load-use stalls, taken-branch flushes and data-memory freezes,
// runs the memory-wait timeout FSM and keeps saturating perf counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal flow; a stalled memory access moves us to MEM_WAIT
// MEM_WAIT | pipeline frozen until dmem_ack_i or the wait budget expires
// ERROR    | memory never answered; frozen and sticky until rst_i
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_br_taken_i,
    input  logic             mem_access_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_en_o,
    output logic             dmem_req_o,
    output logic             err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic lu;
    logic freeze;
    logic stall_inc;

    // Hazard terms; x0 is hardwired zero so it never creates a dependency.
    always_comb begin
        lu = ex_memread_i && (ex_rd_i != 5'd0) &&
             ((ex_rd_i == id_rs1_i) || (id_use_rs2_i && (ex_rd_i == id_rs2_i)));
        freeze = ((state_q == ST_RUN) && mem_access_i && !dmem_ack_i) ||
                 ((state_q == ST_MEM_WAIT) && !dmem_ack_i) ||
                 (state_q == ST_ERROR);
    end

    // Stage enables and flushes by priority: freeze, taken branch, load-use.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_en_o     = 1'b1;
        if (freeze) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_en_o    = 1'b0;
        end else if (ex_br_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (lu) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
        dmem_req_o = mem_access_i && (state_q != ST_ERROR);
    end

    // Memory-wait FSM next state, wait counter and sticky error.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_access_i && !dmem_ack_i) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = ST_RUN;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating perf counters; ERROR cycles are not counted as stalls.
    always_comb begin
        stall_inc   = (lu && !ex_br_taken_i && !freeze) ||
                      (freeze && (state_q != ST_ERROR));
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush_o && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign err_o       = err_q;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with CNT_W=4 and MEM_TIMEOUT=4.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs1 = '0;
    logic [4:0]       id_rs2 = '0;
    logic             id_use_rs2 = 1'b0;
    logic             ex_memread = 1'b0;
    logic [4:0]       ex_rd = '0;
    logic             ex_br_taken = 1'b0;
    logic             mem_access = 1'b0;
    logic             dmem_ack = 1'b0;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en, dmem_req, err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs2_i(id_use_rs2),
        .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .ex_br_taken_i(ex_br_taken),
        .mem_access_i(mem_access), .dmem_ack_i(dmem_ack),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .pipe_en_o(pipe_en), .dmem_req_o(dmem_req),
        .err_o(err), .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got time-out want finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_use_rs2 = 1'b0;
        ex_memread = 1'b0; ex_rd = '0; ex_br_taken = 1'b0;
        mem_access = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        n_vec++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL reset_pc_write: got %b want 1", pc_write); end
        n_vec++; if (ifid_write !== 1'b1) begin n_err++; $display("FAIL reset_ifid_write: got %b want 1", ifid_write); end
        n_vec++; if (pipe_en !== 1'b1) begin n_err++; $display("FAIL reset_pipe_en: got %b want 1", pipe_en); end
        n_vec++; if ({ifid_flush, idex_bubble, dmem_req} !== 3'b000) begin n_err++; $display("FAIL reset_flush_bubble_req: got %b want 000", {ifid_flush, idex_bubble, dmem_req}); end
        n_vec++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", state); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (pipe_en !== 1'b1 || stall_cnt !== 4'd0 || state !== 2'b00) begin n_err++; $display("FAIL idle_after_reset: got en=%b stall=%0d st=%b want 1/0/00", pipe_en, stall_cnt, state); end
    endtask

    task automatic test_load_use();
        // ld x5 in EX, ID reads x5 as rs1
        @(negedge clk);
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        #1;
        n_vec++; if ({pc_write, ifid_write, idex_bubble, pipe_en, ifid_flush} !== 5'b00110) begin n_err++; $display("FAIL lu_rs1_outputs: got %b want 00110", {pc_write, ifid_write, idex_bubble, pipe_en, ifid_flush}); end
        @(posedge clk); #1;
        exp_stall = exp_stall + 1;
        n_vec++; if (stall_cnt !== 4'(exp_stall)) begin n_err++; $display("FAIL lu_rs1_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        // load has advanced: hazard gone
        @(negedge clk);
        clear_inputs(); id_rs1 = 5'd5;
        #1;
        n_vec++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin n_err++; $display("FAIL lu_release: got %b want 110", {pc_write, ifid_write, idex_bubble}); end
        // x0 never hazards
        @(negedge clk);
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #1;
        n_vec++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin n_err++; $display("FAIL lu_x0: got %b want 110", {pc_write, ifid_write, idex_bubble}); end
        @(posedge clk); #1;
        n_vec++; if (stall_cnt !== 4'(exp_stall)) begin n_err++; $display("FAIL lu_x0_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        // rs2 match without use_rs2 is no hazard
        @(negedge clk);
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
        #1;
        n_vec++; if (idex_bubble !== 1'b0 || pc_write !== 1'b1) begin n_err++; $display("FAIL lu_rs2_unused: got bub=%b pc=%b want 0/1", idex_bubble, pc_write); end
        // rs2 match with use_rs2 stalls
        id_use_rs2 = 1'b1;
        #1;
        n_vec++; if (idex_bubble !== 1'b1 || pc_write !== 1'b0) begin n_err++; $display("FAIL lu_rs2_used: got bub=%b pc=%b want 1/0", idex_bubble, pc_write); end
        @(posedge clk); #1;
        exp_stall = exp_stall + 1;
        n_vec++; if (stall_cnt !== 4'(exp_stall)) begin n_err++; $display("FAIL lu_rs2_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        // non-load in EX writing the same register: no hazard
        @(negedge clk);
        ex_memread = 1'b0;
        #1;
        n_vec++; if (idex_bubble !== 1'b0) begin n_err++; $display("FAIL lu_not_load: got %b want 0", idex_bubble); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_branch_lu();
        @(negedge clk);
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; ex_br_taken = 1'b1;
        #1;
        n_vec++; if ({ifid_flush, idex_bubble, pc_write, ifid_write, pipe_en} !== 5'b11111) begin n_err++; $display("FAIL br_lu_outputs: got %b want 11111", {ifid_flush, idex_bubble, pc_write, ifid_write, pipe_en}); end
        @(posedge clk); #1;
        exp_flush = exp_flush + 1;
        n_vec++; if (flush_cnt !== 4'(exp_flush)) begin n_err++; $display("FAIL br_lu_flush_cnt: got %0d want %0d", flush_cnt, exp_flush); end
        n_vec++; if (stall_cnt !== 4'(exp_stall)) begin n_err++; $display("FAIL br_lu_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_access = 1'b1; dmem_ack = 1'b0;
            #1;
            n_vec++; if (pipe_en !== 1'b0 || pc_write !== 1'b0 || dmem_req !== 1'b1) begin n_err++; $display("FAIL mw_frozen[%0d]: got en=%b pc=%b req=%b want 0/0/1", i, pipe_en, pc_write, dmem_req); end
            @(posedge clk); #1;
            n_vec++; if (state !== 2'b01) begin n_err++; $display("FAIL mw_state[%0d]: got %b want 01", i, state); end
        end
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        n_vec++; if (pipe_en !== 1'b1 || pc_write !== 1'b1) begin n_err++; $display("FAIL mw_ack_release: got en=%b pc=%b want 1/1", pipe_en, pc_write); end
        @(posedge clk); #1;
        exp_stall = exp_stall + 3;
        n_vec++; if (state !== 2'b00) begin n_err++; $display("FAIL mw_back_to_run: got %b want 00", state); end
        n_vec++; if (stall_cnt !== 4'(exp_stall)) begin n_err++; $display("FAIL mw_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_ack_ignored();
        @(negedge clk);
        mem_access = 1'b0; dmem_ack = 1'b1;
        #1;
        n_vec++; if (pipe_en !== 1'b1 || dmem_req !== 1'b0) begin n_err++; $display("FAIL stray_ack: got en=%b req=%b want 1/0", pipe_en, dmem_req); end
        @(posedge clk); #1;
        n_vec++; if (state !== 2'b00 || stall_cnt !== 4'(exp_stall)) begin n_err++; $display("FAIL stray_ack_state: got st=%b stall=%0d want 00/%0d", state, stall_cnt, exp_stall); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_branch_freeze();
        @(negedge clk);
        mem_access = 1'b1; dmem_ack = 1'b0; ex_br_taken = 1'b1;
        #1;
        n_vec++; if (ifid_flush !== 1'b0 || idex_bubble !== 1'b0 || pc_write !== 1'b0) begin n_err++; $display("FAIL brf_held: got fl=%b bub=%b pc=%b want 0/0/0", ifid_flush, idex_bubble, pc_write); end
        @(posedge clk); #1;
        n_vec++; if (flush_cnt !== 4'(exp_flush)) begin n_err++; $display("FAIL brf_no_flush_cnt: got %0d want %0d", flush_cnt, exp_flush); end
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        n_vec++; if (ifid_flush !== 1'b1 || idex_bubble !== 1'b1 || pc_write !== 1'b1) begin n_err++; $display("FAIL brf_ack_flush: got fl=%b bub=%b pc=%b want 1/1/1", ifid_flush, idex_bubble, pc_write); end
        @(posedge clk); #1;
        exp_flush = exp_flush + 1;
        exp_stall = exp_stall + 1;
        n_vec++; if (flush_cnt !== 4'(exp_flush) || stall_cnt !== 4'(exp_stall)) begin n_err++; $display("FAIL brf_counters: got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_last_ack();
        do_reset();
        // RUN cycle plus three MEM_WAIT cycles without ack
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_access = 1'b1; dmem_ack = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        n_vec++; if (state !== 2'b01 || pipe_en !== 1'b1) begin n_err++; $display("FAIL last_ack_accept: got st=%b en=%b want 01/1", state, pipe_en); end
        @(posedge clk); #1;
        n_vec++; if (state !== 2'b00 || err !== 1'b0) begin n_err++; $display("FAIL last_ack_run: got st=%b err=%b want 00/0", state, err); end
        n_vec++; if (stall_cnt !== 4'd4) begin n_err++; $display("FAIL last_ack_stall_cnt: got %0d want 4", stall_cnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_access = 1'b1; dmem_ack = 1'b0;
            #1;
            n_vec++; if (pipe_en !== 1'b0) begin n_err++; $display("FAIL to_frozen[%0d]: got %b want 0", i, pipe_en); end
            @(posedge clk); #1;
            if (i < 4) begin
                n_vec++; if (state !== 2'b01) begin n_err++; $display("FAIL to_wait_state[%0d]: got %b want 01", i, state); end
            end
        end
        n_vec++; if (state !== 2'b10) begin n_err++; $display("FAIL to_error_state: got %b want 10", state); end
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        n_vec++; if (dmem_req !== 1'b0 || pipe_en !== 1'b0 || pc_write !== 1'b0) begin n_err++; $display("FAIL to_error_outputs: got req=%b en=%b pc=%b want 0/0/0", dmem_req, pipe_en, pc_write); end
        @(posedge clk); #1;
        n_vec++; if (err !== 1'b1 || state !== 2'b10) begin n_err++; $display("FAIL to_err_sticky: got err=%b st=%b want 1/10", err, state); end
        n_vec++; if (stall_cnt !== 4'd5) begin n_err++; $display("FAIL to_stall_cnt: got %0d want 5", stall_cnt); end
        // asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (err !== 1'b0 || state !== 2'b00 || stall_cnt !== 4'd0) begin n_err++; $display("FAIL to_async_reset: got err=%b st=%b stall=%0d want 0/00/0", err, state, stall_cnt); end
        n_vec++; if (pipe_en !== 1'b1 || dmem_req !== 1'b1) begin n_err++; $display("FAIL to_reset_outputs: got en=%b req=%b want 1/1", pipe_en, dmem_req); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ex_memread = 1'b1; ex_rd = 5'd12; id_rs1 = 5'd12;
            @(posedge clk); #1;
            exp_stall = (i + 1 > 15) ? 15 : i + 1;
            n_vec++; if (stall_cnt !== 4'(exp_stall)) begin n_err++; $display("FAIL sat_stall[%0d]: got %0d want %0d", i, stall_cnt, exp_stall); end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_ack_ignored();
        test_branch_freeze();
        test_last_ack();
        test_timeout();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside the main decoder and owns every stage-register enable and flush: load-use stalls, taken-branch flushes, and a full-pipeline freeze while the data memory holds off a load/store through a req/ack handshake. It also holds a memory-wait timeout FSM with a sticky error flag, and saturating stall/flush counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters
- MEM_TIMEOUT, 8, maximum number of MEM_WAIT cycles before ERROR (≥1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- id_rs1_i  in  5  rs1 of the instruction in ID
- id_rs2_i  in  5  rs2 of the instruction in ID
- id_use_rs2_i  in  1  ID instruction reads rs2 (R-format, sd, beq)
- ex_memread_i  in  1  MemRead of the instruction in EX
- ex_rd_i  in  5  rd of the instruction in EX
- ex_br_taken_i  in  1  branch in EX resolved taken (Branch & zero)
- mem_access_i  in  1  MEM instruction has MemRead or MemWrite
- dmem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC register enable
- ifid_write_o  out  1  IF/ID enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_bubble_o  out  1  ID/EX loads zeroed control signals
- pipe_en_o  out  1  ID/EX, EX/MEM, MEM/WB enable
- dmem_req_o  out  1  data memory request
- err_o  out  1  sticky memory-timeout error
- state_o  out  2  FSM state (RUN=00, MEM_WAIT=01, ERROR=10)
- stall_cnt_o  out  CNT_W  saturating stall-cycle count
- flush_cnt_o  out  CNT_W  saturating flush count

## Operation
- Internal terms:
  - lu = ex_memread_i & ex_rd_i≠0 & (ex_rd_i==id_rs1_i | (id_use_rs2_i & ex_rd_i==id_rs2_i)). x0 never hazards.
  - freeze = (RUN & mem_access_i & ~dmem_ack_i) | (MEM_WAIT & ~dmem_ack_i) | ERROR.
- Priority, highest first:
  - freeze: pc_write_o, ifid_write_o and pipe_en_o = 0; ifid_flush_o and idex_bubble_o = 0. Branch and lu are held and re-evaluated once the freeze lifts.
  - ex_br_taken_i: ifid_flush_o = 1, idex_bubble_o = 1, pc_write_o = 1, ifid_write_o = 1. Overrides lu, because the stalled instruction is wrong-path.
  - lu: pc_write_o = 0, ifid_write_o = 0, idex_bubble_o = 1, pipe_en_o = 1.
  - otherwise all enables are 1 and all flushes are 0.
- dmem_req_o = mem_access_i & state≠ERROR.
- FSM (registered), with a wait counter wcnt of width clog2(MEM_TIMEOUT)+1:
  - RUN: mem_access_i & ~dmem_ack_i → MEM_WAIT, wcnt←0. Otherwise stay in RUN.
  - MEM_WAIT: dmem_ack_i → RUN, and that cycle is not frozen. Else if wcnt==MEM_TIMEOUT-1 → ERROR. Else wcnt++.
  - ERROR: err_o←1 and the pipeline stays frozen. Only rst_i exits this state.
- Counters:
  - stall_cnt increments in every cycle where (lu & ~ex_br_taken_i & ~freeze) or (freeze & state≠ERROR).
  - flush_cnt increments in every cycle where ifid_flush_o = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, immediate): state RUN, wcnt 0, err_o 0, both counters 0.
- Outputs with all inputs at 0 during or after reset: pc_write_o, ifid_write_o and pipe_en_o = 1; ifid_flush_o, idex_bubble_o and dmem_req_o = 0.
- All enable, flush and request outputs are combinational from the inputs and the current state, with zero latency. state_o, err_o and the counters change only on clk_i edges.
- Load-use costs exactly 1 bubble. The load advances to MEM the next cycle, so lu drops.
- Handshake: an access is complete in the first cycle with dmem_req_o & dmem_ack_i. An ack while mem_access_i=0 is ignored.
- Worst-case freeze before ERROR is 1 + MEM_TIMEOUT cycles. An ack in the MEM_TIMEOUT-th MEM_WAIT cycle is still accepted.
- Reset asserted during MEM_WAIT or ERROR returns to RUN at once. Any outstanding request is dropped.

## Test plan
- Load-use: ld x5 in EX (ex_memread_i=1, ex_rd_i=5), id_rs1_i=5 → one cycle with pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o 0→1. Repeat with ex_rd_i=0 → no stall.
- Branch plus load-use in the same cycle: ex_br_taken_i=1 and lu=1 → ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1; flush_cnt_o +1; stall_cnt_o unchanged.
- Memory wait: mem_access_i=1, ack held low for 3 cycles then high → pipe_en_o=0 for 3 cycles; state_o goes 01 then 00; stall_cnt_o +3; released in the ack cycle.
- Timeout: MEM_TIMEOUT=4, ack never asserted → ERROR entered 5 cycles after the request; err_o=1; state_o=10; dmem_req_o=0; freeze persists. Async rst_i mid-ERROR → err_o=0 and state RUN without a clock edge.
- Saturation: CNT_W=4, 20 consecutive load-use stalls → stall_cnt_o holds at 15.
- Branch during freeze: ex_br_taken_i=1 while frozen → ifid_flush_o=0 until the ack cycle, then 1.
